// File: rtl/abp_pkg.sv
`default_nettype none
// ============================================================================
// Module   : abp_pkg
// Purpose  : Shared types and constants for the Alternating Bit Protocol
//            receive-side controller.
// Contents : abp_rx_state_t   - controller state encoding
//            ABP_INIT_BIT     - expected bit value after reset
//            abp_value_bits() - value width in bits from a width in bytes
// Revision : 1.0 - initial release
// ============================================================================
package abp_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        DELIVER = 2'd1,
        ACK     = 2'd2
    } abp_rx_state_t;

    localparam logic ABP_INIT_BIT      = 1'b0;
    localparam int   ABP_BITS_PER_BYTE = 8;

    function automatic int abp_value_bits(input int value_size);
        return value_size * ABP_BITS_PER_BYTE;
    endfunction

endpackage
`default_nettype wire

// File: rtl/abp_sat_counter.sv
`default_nettype none
// ============================================================================
// Module   : abp_sat_counter
// Purpose  : Event counter that sticks at all-ones instead of wrapping.
//            A clear on the same cycle as an increment wins and yields zero.
// Ports    : aclk   - clock
//            resetn - asynchronous active-low reset
//            inc    - count one event this cycle
//            clr    - synchronous clear
//            count  - current count (registered)
// Revision : 1.0 - initial release
// ============================================================================
module abp_sat_counter #(
    parameter int COUNT_WIDTH = 16
) (
    input  logic                   aclk,
    input  logic                   resetn,
    input  logic                   inc,
    input  logic                   clr,
    output logic [COUNT_WIDTH-1:0] count
);

    logic [COUNT_WIDTH-1:0] count_q;
    logic [COUNT_WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (inc && (count_q != {COUNT_WIDTH{1'b1}})) begin
            count_d = count_q + {{(COUNT_WIDTH-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge aclk or negedge resetn) begin
        if (!resetn) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule
`default_nettype wire

// File: rtl/abp_rx_controller.sv
`default_nettype none
// ============================================================================
// Module   : abp_rx_controller
// Purpose  : Receive-side Alternating Bit Protocol sequencer. Takes decoded
//            frames one at a time, delivers frames carrying the expected bit,
//            drops duplicates, and requests an ACK for every frame received.
//            Keeps saturating counters of accepted, duplicate and
//            early-termination events.
// Ports    : aclk, resetn                  - clock, async active-low reset
//            abp_rx_valid/value/bit/ready  - frame input from abp_packet_rx
//            rx_error_early_termination    - level error flag (edge counted)
//            out_valid/value/ready         - delivered value to user sink
//            ack_valid/bit/ready           - ACK request to transmit path
//            clear_counters                - synchronous counter clear
//            expected_bit                  - bit the next new frame carries
//            accepted/duplicate/error_count - status counters
// Revision : 1.0 - initial release
// ============================================================================
module abp_rx_controller
    import abp_pkg::*;
#(
    parameter int VALUE_SIZE  = 4,
    parameter int COUNT_WIDTH = 16
) (
    input  logic                                      aclk,
    input  logic                                      resetn,
    input  logic                                      abp_rx_valid,
    input  logic [VALUE_SIZE*ABP_BITS_PER_BYTE-1:0]   abp_rx_value,
    input  logic                                      abp_rx_bit,
    output logic                                      abp_rx_ready,
    input  logic                                      rx_error_early_termination,
    output logic                                      out_valid,
    output logic [VALUE_SIZE*ABP_BITS_PER_BYTE-1:0]   out_value,
    input  logic                                      out_ready,
    output logic                                      ack_valid,
    output logic                                      ack_bit,
    input  logic                                      ack_ready,
    input  logic                                      clear_counters,
    output logic                                      expected_bit,
    output logic [COUNT_WIDTH-1:0]                    accepted_count,
    output logic [COUNT_WIDTH-1:0]                    duplicate_count,
    output logic [COUNT_WIDTH-1:0]                    error_count
);

    localparam int VALUE_W = abp_value_bits(VALUE_SIZE);

    abp_rx_state_t        state_q, state_d;
    logic                 expected_bit_q, expected_bit_d;
    logic [VALUE_W-1:0]   out_value_q, out_value_d;
    logic                 ack_bit_q, ack_bit_d;
    logic                 abp_rx_ready_q, abp_rx_ready_d;
    logic                 out_valid_q, out_valid_d;
    logic                 ack_valid_q, ack_valid_d;
    logic                 err_prev_q, err_prev_d;

    logic                 inc_accepted;
    logic                 inc_duplicate;
    logic                 inc_error;

    // ------------------------------------------------------------------
    // Next-state and registered-output logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d        = state_q;
        expected_bit_d = expected_bit_q;
        out_value_d    = out_value_q;
        ack_bit_d      = ack_bit_q;
        inc_accepted   = 1'b0;
        inc_duplicate  = 1'b0;

        case (state_q)
            IDLE: begin
                // Gate on the registered ready so a frame offered while
                // ready is still low (first cycle after reset) is ignored.
                if (abp_rx_ready_q && abp_rx_valid) begin
                    if (abp_rx_bit == expected_bit_q) begin
                        out_value_d  = abp_rx_value;
                        state_d      = DELIVER;
                        inc_accepted = 1'b1;
                    end else begin
                        ack_bit_d     = abp_rx_bit;
                        state_d       = ACK;
                        inc_duplicate = 1'b1;
                    end
                end
            end
            DELIVER: begin
                if (out_ready) begin
                    ack_bit_d = expected_bit_q;
                    state_d   = ACK;
                end
            end
            ACK: begin
                if (ack_ready) begin
                    state_d = IDLE;
                    // Only the ACK of a newly delivered frame advances the
                    // expected bit; a duplicate carries the other bit.
                    if (ack_bit_q == expected_bit_q) begin
                        expected_bit_d = ~expected_bit_q;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Handshake outputs are registered copies of the next state.
        abp_rx_ready_d = (state_d == IDLE);
        out_valid_d    = (state_d == DELIVER);
        ack_valid_d    = (state_d == ACK);
    end

    // Rising-edge detect: a held error level counts once.
    always_comb begin
        err_prev_d = rx_error_early_termination;
        inc_error  = rx_error_early_termination & ~err_prev_q;
    end

    always_ff @(posedge aclk or negedge resetn) begin
        if (!resetn) begin
            state_q        <= IDLE;
            expected_bit_q <= ABP_INIT_BIT;
            out_value_q    <= '0;
            ack_bit_q      <= 1'b0;
            abp_rx_ready_q <= 1'b0;
            out_valid_q    <= 1'b0;
            ack_valid_q    <= 1'b0;
            err_prev_q     <= 1'b0;
        end else begin
            state_q        <= state_d;
            expected_bit_q <= expected_bit_d;
            out_value_q    <= out_value_d;
            ack_bit_q      <= ack_bit_d;
            abp_rx_ready_q <= abp_rx_ready_d;
            out_valid_q    <= out_valid_d;
            ack_valid_q    <= ack_valid_d;
            err_prev_q     <= err_prev_d;
        end
    end

    // ------------------------------------------------------------------
    // Status counters
    // ------------------------------------------------------------------
    abp_sat_counter #(.COUNT_WIDTH(COUNT_WIDTH)) u_accepted_cnt (
        .aclk   (aclk),
        .resetn (resetn),
        .inc    (inc_accepted),
        .clr    (clear_counters),
        .count  (accepted_count)
    );

    abp_sat_counter #(.COUNT_WIDTH(COUNT_WIDTH)) u_duplicate_cnt (
        .aclk   (aclk),
        .resetn (resetn),
        .inc    (inc_duplicate),
        .clr    (clear_counters),
        .count  (duplicate_count)
    );

    abp_sat_counter #(.COUNT_WIDTH(COUNT_WIDTH)) u_error_cnt (
        .aclk   (aclk),
        .resetn (resetn),
        .inc    (inc_error),
        .clr    (clear_counters),
        .count  (error_count)
    );

    assign abp_rx_ready = abp_rx_ready_q;
    assign out_valid    = out_valid_q;
    assign out_value    = out_value_q;
    assign ack_valid    = ack_valid_q;
    assign ack_bit      = ack_bit_q;
    assign expected_bit = expected_bit_q;

endmodule
`default_nettype wire
